// File: rtl/barrett_for_151.sv
// Fixed-modulus Barrett reducer: dout_r = din_a mod 151, registered, one-cycle latency.
// The quotient is estimated with the reciprocal 434 = floor(2^16/151) and a 16-bit shift.
// Over the full 15-bit operand range that estimate is low by at most one, so a single
// conditional subtract yields the exact residue.
module barrett_for_151 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] din_a,
  output logic [7:0]  dout_r
);

  localparam logic [15:0] MODULUS = 16'd151;

  logic [23:0] prod_a;   // din_a * 434
  logic [7:0]  quot_a;   // quotient estimate, at most 216
  logic [15:0] mult_b;   // quot_a * 151
  logic [15:0] rem_b;    // remainder estimate, always in 0..301
  logic [7:0]  res_c;    // corrected residue, 0..150

  // One conditional subtract brings a remainder in 0..2n-1 into 0..n-1.
  function automatic logic [7:0] correct_once(input logic [15:0] r);
    return 8'((r >= MODULUS) ? (r - MODULUS) : r);
  endfunction

  // Stage A: quotient estimate, 434 = 256 + 128 + 32 + 16 + 2 as a shift-add network.
  always_comb begin
    logic [23:0] x;
    x      = {9'd0, din_a};
    prod_a = (x << 8) + (x << 7) + (x << 5) + (x << 4) + (x << 1);
    quot_a = prod_a[23:16];
  end

  // Stage B: remainder estimate, 151 = 128 + 16 + 4 + 2 + 1 as a shift-add network.
  always_comb begin
    logic [15:0] y;
    y      = {8'd0, quot_a};
    mult_b = (y << 7) + (y << 4) + (y << 2) + (y << 1) + y;
    rem_b  = {1'b0, din_a} - mult_b;
  end

  // Stage C: single correction step.
  always_comb begin
    res_c = correct_once(rem_b);
  end

  // Output register; asynchronous clear discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_r <= 8'd0;
    else        dout_r <= res_c;
  end

endmodule

// File: tb/tb_barrett_for_151.sv
// Self-checking bench for barrett_for_151: directed corners, exhaustive sweep,
// random operands and reset/latency behaviour against a plain modulo reference.
module tb_barrett_for_151;

  logic        clk;
  logic        rst_n;
  logic [14:0] din_a;
  logic [7:0]  dout_r;

  int checks = 0;
  int errors = 0;

  barrett_for_151 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_a  (din_a),
    .dout_r (dout_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference residue straight from the definition.
  function automatic logic [7:0] ref_mod(input int unsigned v);
    return 8'(v % 151);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [7:0] obs);
    checks++;
    assert (!$isunknown(obs) && obs <= 8'd150) else begin
      errors++;
      $error("FAIL %s: observed %0d expected <= 150", tag, obs);
    end
  endtask

  // Change operand on the falling edge, sample just after the next rising edge.
  task automatic apply(input int unsigned v);
    @(negedge clk);
    din_a = 15'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_check(input string tag, input int unsigned v, input int unsigned exp);
    apply(v);
    check($sformatf("%s(%0d)", tag, v), dout_r, 8'(exp));
  endtask

  initial begin
    int unsigned v;

    // Reset held from time 0
    rst_n = 1'b0;
    din_a = 15'd1000;
    #2;
    check("reset_t0", dout_r, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_clocks", dout_r, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_1000", dout_r, ref_mod(1000));

    // Identity range
    for (int i = 0; i <= 150; i++) apply_check("identity", i, i);

    // Modulus boundaries and quotient-underestimate corners
    apply_check("bound", 151, 0);
    apply_check("bound", 152, 1);
    apply_check("bound", 301, 150);
    apply_check("bound", 302, 0);
    apply_check("bound", 1000, 94);
    apply_check("corner", 22800, 150);
    apply_check("corner", 22801, 0);
    apply_check("corner", 32766, 150);
    apply_check("corner", 32767, 0);

    // Exhaustive sweep, back to back
    for (int i = 0; i < 32768; i++) begin
      apply(i);
      check($sformatf("sweep(%0d)", i), dout_r, ref_mod(i));
      check_range($sformatf("sweep_range(%0d)", i), dout_r);
    end

    // Random operands, back to back
    for (int i = 0; i < 300; i++) begin
      v = $urandom_range(0, 32767);
      apply(v);
      check($sformatf("rand(%0d)", v), dout_r, ref_mod(v));
    end

    // Mid-stream asynchronous reset
    apply_check("pre_reset", 1000, 94);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", dout_r, 8'd0);
    @(negedge clk);
    din_a = 15'd1000;
    rst_n = 1'b1;
    #1;
    check("after_release_no_edge", dout_r, 8'd0);
    @(posedge clk);
    #1;
    check("after_release_edge", dout_r, 8'd94);

    // Latency: operand change between edges must not reach the output early
    apply_check("lat_first", 5, 5);
    @(negedge clk);
    din_a = 15'd160;
    #1;
    check("lat_hold", dout_r, 8'd5);
    @(posedge clk);
    #1;
    check("lat_update", dout_r, 8'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
